// File: rtl/if_fetch_buffer.sv
// IF-stage fetch buffer: reads instruction memory at the IF PC and queues
// {pc, instruction} pairs for decode, with flush on redirect and stall back-pressure.
module if_fetch_buffer #(
  parameter int                AWIDTH       = 32,
  parameter int                IMEM_AWIDTH  = 14,
  parameter int                DEPTH        = 4,
  parameter logic [AWIDTH-1:0] RESET_PC_VAL = 32'h4000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AWIDTH-1:0]      pc_in,
  input  logic                   pc_sel_in,
  output logic                   stall_out,
  output logic                   imem_en_out,
  output logic [IMEM_AWIDTH-1:0] imem_addr_out,
  input  logic [31:0]            imem_dout_in,
  output logic [31:0]            inst_out,
  output logic [AWIDTH-1:0]      inst_pc_out,
  output logic                   inst_misaligned_out,
  output logic                   inst_valid_out,
  input  logic                   inst_ready_in
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic              req_vld_p1;
  logic [AWIDTH-1:0] req_pc_p1;
  logic [PW:0]       count;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic              rsp_mis;

  logic [31:0]       fifo_inst [DEPTH];
  logic [AWIDTH-1:0] fifo_pc   [DEPTH];
  logic              fifo_mis  [DEPTH];

  // Misaligned fetches never hand raw memory data to decode.
  function automatic logic [31:0] resp_word(input logic mis, input logic [31:0] raw);
    return mis ? NOP : raw;
  endfunction

  // Stage p0: issue the read; occupancy counts the in-flight response as a slot.
  always_comb begin
    occupancy     = count + {{PW{1'b0}}, req_vld_p1};
    stall_out     = occupancy >= DEPTH_C;
    issue         = !rst && !stall_out && !pc_sel_in;
    imem_en_out   = issue;
    imem_addr_out = pc_in[IMEM_AWIDTH+1:2];
  end

  // Stage p1: memory data returns; push unless a redirect kills it.
  always_comb begin
    rsp_mis        = req_pc_p1[1:0] != 2'b00;
    inst_valid_out = count != '0;
    push           = req_vld_p1 && !pc_sel_in;
    pop            = inst_valid_out && inst_ready_in && !pc_sel_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_p1 <= 1'b0;
      count      <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      req_vld_p1 <= issue;
      if (pc_sel_in) begin
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_ONE;
        if (pop)  rptr <= rptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc_p1 <= pc_in;
    if (push) begin
      fifo_inst[wptr] <= resp_word(rsp_mis, imem_dout_in);
      fifo_pc[wptr]   <= req_pc_p1;
      fifo_mis[wptr]  <= rsp_mis;
    end
  end

  // Stage p2: FIFO head to decode; empty buffer presents a NOP at the reset PC.
  always_comb begin
    inst_out            = NOP;
    inst_pc_out         = RESET_PC_VAL;
    inst_misaligned_out = 1'b0;
    if (inst_valid_out) begin
      inst_out            = fifo_inst[rptr];
      inst_pc_out         = fifo_pc[rptr];
      inst_misaligned_out = fifo_mis[rptr];
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Randomized scoreboard bench for if_fetch_buffer with a queue-based reference model.
module tb_if_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_sel_in;
  logic        stall_out;
  logic        imem_en_out;
  logic [13:0] imem_addr_out;
  logic [31:0] imem_dout_in;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        inst_misaligned_out;
  logic        inst_valid_out;
  logic        inst_ready_in;

  if_fetch_buffer #(
    .AWIDTH(32), .IMEM_AWIDTH(14), .DEPTH(DEPTH), .RESET_PC_VAL(32'h4000_0000)
  ) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_sel_in(pc_sel_in),
    .stall_out(stall_out), .imem_en_out(imem_en_out), .imem_addr_out(imem_addr_out),
    .imem_dout_in(imem_dout_in), .inst_out(inst_out), .inst_pc_out(inst_pc_out),
    .inst_misaligned_out(inst_misaligned_out), .inst_valid_out(inst_valid_out),
    .inst_ready_in(inst_ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        e;
  logic        mdl_inflight = 1'b0;
  logic [31:0] mdl_pc = '0;
  logic        stall_m = 1'b0;
  logic        exp_en;
  logic        saw_stall = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          delivered = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: fetch requested at a clock edge becomes a queue entry one edge later.
  always @(posedge clk) begin
    if (rst || pc_sel_in) begin
      exp_q.delete();
      mdl_inflight = 1'b0;
    end else begin
      if (mdl_inflight) begin
        e.pc   = mdl_pc;
        e.mis  = mdl_pc[1:0] != 2'b00;
        e.inst = e.mis ? 32'h0000_0013 : 32'hA000_0000 + {18'b0, mdl_pc[15:2]};
        exp_q.push_back(e);
      end
      mdl_inflight = !stall_m;
      mdl_pc       = pc_in;
    end
  end

  // Monitor: compare what the DUT presents mid-cycle, pop on an accepted handshake.
  always @(negedge clk) begin
    stall_m = (exp_q.size() + int'(mdl_inflight)) >= DEPTH;
    if (stall_out) saw_stall = 1'b1;
    chk("stall", 32'(stall_out), 32'(stall_m));
    chk("valid", 32'(inst_valid_out), 32'(exp_q.size() != 0));
    if (inst_valid_out && exp_q.size() != 0) begin
      chk("head_inst", inst_out, exp_q[0].inst);
      chk("head_pc", inst_pc_out, exp_q[0].pc);
      chk("head_mis", 32'(inst_misaligned_out), 32'(exp_q[0].mis));
    end else if (!inst_valid_out) begin
      chk("empty_inst", inst_out, 32'h0000_0013);
      chk("empty_pc", inst_pc_out, 32'h4000_0000);
      chk("empty_mis", 32'(inst_misaligned_out), 32'd0);
    end
    exp_en = !rst && !stall_m && !pc_sel_in;
    chk("imem_en", 32'(imem_en_out), 32'(exp_en));
    if (imem_en_out) chk("imem_addr", {18'b0, imem_addr_out}, {18'b0, pc_in[15:2]});
    if (!rst && !pc_sel_in && inst_valid_out && inst_ready_in && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      delivered++;
    end
  end

  // One clock cycle: apply controls, then emulate IF's PC and the synchronous memory.
  task automatic tick(input logic r, input logic sel, input logic rdy, input logic [31:0] tgt);
    logic        st;
    logic        en;
    logic [13:0] ad;
    rst           = r;
    pc_sel_in     = sel;
    inst_ready_in = rdy;
    @(negedge clk);
    st = stall_out;
    en = imem_en_out;
    ad = imem_addr_out;
    @(posedge clk);
    #1;
    imem_dout_in = en ? 32'hA000_0000 + {18'b0, ad} : 32'hDEAD_BEEF;
    if (r)        pc_in = 32'h4000_0000;
    else if (sel) pc_in = tgt;
    else if (!st) pc_in = pc_in + 32'd4;
  endtask

  initial begin
    logic [31:0] t;
    int unsigned rv;
    rst           = 1'b1;
    pc_sel_in     = 1'b0;
    inst_ready_in = 1'b1;
    pc_in         = 32'h4000_0000;
    imem_dout_in  = 32'hDEAD_BEEF;

    // Reset then streaming run.
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1, '0);
    chk("rst_valid", 32'(inst_valid_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_en", 32'(imem_en_out), 32'd0);
    tick(1'b0, 1'b0, 1'b1, '0);
    chk("lat_valid1", 32'(inst_valid_out), 32'd0);
    tick(1'b0, 1'b0, 1'b1, '0);
    chk("first_valid", 32'(inst_valid_out), 32'd1);
    chk("first_pc", inst_pc_out, 32'h4000_0000);
    chk("first_inst", inst_out, 32'hA000_0000);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, '0);

    // Back-pressure until stall, then drain.
    for (int i = 0; i < 20 && !stall_out; i++) tick(1'b0, 1'b0, 1'b0, '0);
    chk("bp_stall", 32'(stall_out), 32'd1);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b1, '0);

    // Redirect with 2 buffered and 1 in flight.
    for (int i = 0; i < 10 && !(exp_q.size() == 2 && mdl_inflight); i++) tick(1'b0, 1'b0, 1'b0, '0);
    chk("redir_setup", 32'(exp_q.size() == 2 && mdl_inflight), 32'd1);
    tick(1'b0, 1'b1, 1'b0, 32'h2000_0000);
    chk("redir_valid", 32'(inst_valid_out), 32'd0);
    chk("redir_stall", 32'(stall_out), 32'd0);
    for (int i = 0; i < 10 && !inst_valid_out; i++) tick(1'b0, 1'b0, 1'b1, '0);
    chk("redir_pc0", inst_pc_out, 32'h2000_0000);
    tick(1'b0, 1'b0, 1'b1, '0);
    chk("redir_pc1", inst_pc_out, 32'h2000_0004);

    // Flush while stalled with ready high.
    for (int i = 0; i < 20 && !stall_out; i++) tick(1'b0, 1'b0, 1'b0, '0);
    chk("fl_stall_pre", 32'(stall_out), 32'd1);
    tick(1'b0, 1'b1, 1'b1, 32'h3000_0000);
    chk("fl_valid", 32'(inst_valid_out), 32'd0);
    chk("fl_stall", 32'(stall_out), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, '0);

    // Misaligned PC.
    tick(1'b0, 1'b1, 1'b1, 32'h4000_0002);
    for (int i = 0; i < 10 && !inst_valid_out; i++) tick(1'b0, 1'b0, 1'b1, '0);
    chk("mis_flag", 32'(inst_misaligned_out), 32'd1);
    chk("mis_inst", inst_out, 32'h0000_0013);
    chk("mis_pc", inst_pc_out, 32'h4000_0002);
    tick(1'b0, 1'b1, 1'b1, 32'h4000_0100);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, '0);

    // Reset mid-stream with 3 buffered.
    for (int i = 0; i < 10 && exp_q.size() != 3; i++) tick(1'b0, 1'b0, 1'b0, '0);
    chk("mrst_setup", 32'(exp_q.size()), 32'd3);
    tick(1'b1, 1'b0, 1'b0, '0);
    chk("mrst_valid", 32'(inst_valid_out), 32'd0);
    chk("mrst_stall", 32'(stall_out), 32'd0);
    chk("mrst_en", 32'(imem_en_out), 32'd0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1, '0);

    // Randomized traffic: ready, redirects (some misaligned, random upper bits), resets.
    for (int i = 0; i < 600; i++) begin
      rv = $urandom_range(0, 99);
      t  = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if (rv < 2)      tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), '0);
      else if (rv < 9) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), t);
      else             tick(1'b0, 1'b0, 1'($urandom_range(0, 9) < 7), '0);
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b1, '0);

    chk("saw_stall", 32'(saw_stall), 32'd1);
    chk("delivered", 32'(delivered > 100), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- Consumer end of the IF stage's PC interface: takes `pc_out` from the IF stage and reads the synchronous instruction memory at that PC.
- Queues each returned instruction with its PC in a small FIFO and presents it to decode with a valid/ready handshake.
- Kills in-flight and buffered fetches when IF is redirected (`pc_sel`).
- Drives `stall_out` back to IF so the PC holds while the buffer cannot accept another fetch.

Parameters:
- AWIDTH, 32, PC width.
- IMEM_AWIDTH, 14, instruction memory word-address width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC_VAL, 32'h4000_0000, PC reported on `inst_pc_out` while empty.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc_in  in  AWIDTH  current PC from IF `pc_out`
- pc_sel_in  in  1  redirect; same signal as IF `pc_sel_in`; acts as flush
- stall_out  out  1  IF must hold PC this cycle
- imem_en_out  out  1  memory read enable
- imem_addr_out  out  IMEM_AWIDTH  word address, equal to `pc_in[IMEM_AWIDTH+1:2]`
- imem_dout_in  in  32  read data, valid the cycle after `imem_en_out`
- inst_out  out  32  instruction at FIFO head
- inst_pc_out  out  AWIDTH  PC of `inst_out`
- inst_misaligned_out  out  1  head entry came from a misaligned PC
- inst_valid_out  out  1  FIFO non-empty
- inst_ready_in  in  1  decode accepts head

Behaviour:
- Reset (clk edge with rst=1) clears:
  - `count` to 0, `req_valid_q` to 0, read/write pointers to 0.
  - Next cycle: `inst_valid_out`=0, `stall_out`=0, `imem_en_out`=0.
- While rst=1, `imem_en_out` is forced to 0.
- Empty FIFO outputs: `inst_out`=32'h0000_0013 (NOP), `inst_pc_out`=RESET_PC_VAL, `inst_misaligned_out`=0.
- Stall:
  - `stall_out` = (`count` + `req_valid_q`) >= DEPTH; it is independent of `inst_ready_in`.
  - This guarantees no overflow: pushes never exceed DEPTH.
- Issue (cycle t):
  - Condition: rst=0, `stall_out`=0, `pc_sel_in`=0.
  - Outputs: `imem_en_out`=1, `imem_addr_out`=`pc_in[IMEM_AWIDTH+1:2]`.
  - Registers at the edge: `req_valid_q`=1, `req_pc_q`=`pc_in`.
  - Otherwise `imem_en_out`=0 and `req_valid_q` becomes 0.
- Response (cycle t+1):
  - If `req_valid_q`=1 and `pc_sel_in`=0, push {`req_pc_q`, `imem_dout_in`, misaligned} at the edge.
  - misaligned = `req_pc_q[1:0]` != 0; a misaligned entry stores NOP in place of the data.
- Output:
  - Head entry is visible from cycle t+2, so fetch-to-decode latency is 2 cycles.
  - Pop when `inst_valid_out` & `inst_ready_in`.
  - Push and pop in the same cycle: both happen, `count` unchanged.
- Throughput: with `inst_ready_in` held at 1, one instruction per cycle in steady state (`count`=1, `req_valid_q`=1, occupancy 2 < DEPTH).
- Flush (`pc_sel_in`=1 in cycle t):
  - Response in flight in cycle t is discarded.
  - FIFO emptied at the edge; any pop in cycle t is ignored; `req_valid_q` becomes 0.
  - No request issued in cycle t.
  - Cycle t+1: `inst_valid_out`=0, `stall_out`=0, and the redirected `pc_in` is issued.
  - Flush has priority over stall, push and pop.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; `count` is log2(DEPTH)+1 bits.
- Reset mid-operation: the in-flight response is dropped; state is identical to power-on reset.
- `pc_in` upper bits above IMEM_AWIDTH+1 are ignored for addressing but kept in full in `inst_pc_out`.

Test Plan:
- Reset then run:
  - Stimulus: rst for 10 cycles, release; `pc_in` follows IF from 32'h4000_0000, ready=1, memory word k = 32'hA000_0000+k.
  - Required: `inst_valid_out`=0 for the first 2 cycles after release; then entries (32'h4000_0000, 32'hA000_0000), (32'h4000_0004, 32'hA000_0001), ... one per cycle.
- Back-pressure:
  - Stimulus: ready=0 from the first valid cycle.
  - Required: `stall_out`=1 once 4 entries are held/in flight; `imem_en_out`=0 while stalled; `count` never exceeds 4.
  - Then raise ready: entries drain in order, no loss or duplication, stall drops.
- Redirect:
  - Stimulus: `pc_sel_in`=1 for one cycle while 2 entries are buffered and 1 is in flight; IF moves to 32'h2000_0000.
  - Required: next cycle valid=0; first delivered entry has PC 32'h2000_0000, then 32'h2000_0004.
- Flush while stalled with ready=1 in the same cycle:
  - Required: no pop is observed, buffer is empty next cycle, `stall_out`=0.
- Misaligned PC:
  - Stimulus: `pc_in`=32'h4000_0002.
  - Required: delivered entry has `inst_misaligned_out`=1, `inst_out`=32'h0000_0013, `inst_pc_out`=32'h4000_0002.
- Reset mid-stream:
  - Stimulus: rst for 1 cycle with 3 entries buffered.
  - Required: next cycle valid=0, `stall_out`=0, `imem_en_out`=0; the in-flight response never appears.
